// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding,
// parity-sense constants and a frame-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  // Clock cycles occupied by one complete frame on the line.
  function automatic int frame_clks(input int dw, input int par_en,
                                    input int stop_bits, input int cpb);
    return (1 + dw + par_en + stop_bits) * cpb;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock word FIFO. The caller qualifies push/pop; a push and a pop
// in the same cycle are legal even when full and leave the count unchanged.
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic                            pop,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; payload is not reset, only the pointers that qualify it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign count   = count_q;
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: queued words are serialised as
// start / data (LSB first) / optional parity / stop bits, with zero idle gap
// between frames whenever the queue is non-empty at the end of a stop bit.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int PAR_EN       = 1,
  parameter int PAR_TYPE     = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           P_DATA_IN_TX,
  input  logic                            DATA_VALID_TX,
  output logic                            tx_out,
  output logic                            busy_flag_TX,
  output logic                            data_lost_TX,
  output logic                            fifo_full,
  output logic                            fifo_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              PAR_INV   = (PAR_TYPE == PAR_ODD);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_buffered: FIFO_DEPTH must be a power of two >= 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("uart_tx_buffered: CLKS_PER_BIT must be >= 1");
  end
  if ((PAR_TYPE != PAR_EVEN) && (PAR_TYPE != PAR_ODD)) begin : g_bad_par
    $error("uart_tx_buffered: PAR_TYPE must be 0 or 1");
  end

  uart_state_t           state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, lost_q;
  logic                  pop, push_ok, start_frame, baud_last;
  logic [DATA_WIDTH-1:0] rd_data;

  // A full queue still accepts a word in the cycle the FSM pops one.
  assign push_ok   = DATA_VALID_TX && (!fifo_full || pop);
  assign baud_last = (baud_q == BAUD_LAST);

  uart_sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push_ok),
    .pop    (pop),
    .wr_data(P_DATA_IN_TX),
    .rd_data(rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Next-state, counter and shift logic; tx level is derived from the next state so the pin is registered.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    pop         = 1'b0;
    start_frame = 1'b0;
    tx_d        = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) start_frame = 1'b1;
      end
      ST_START: begin
        if (baud_last) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            state_d = (PAR_EN != 0) ? ST_PARITY : ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (baud_last) begin
          state_d = ST_STOP;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (!fifo_empty) start_frame = 1'b1;
            else             state_d     = ST_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_frame) begin
      pop     = 1'b1;
      shift_d = rd_data;
      par_d   = (^rd_data) ^ PAR_INV;
      state_d = ST_START;
      baud_d  = '0;
      bit_d   = '0;
    end
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // Control state and registered line/flag outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != ST_IDLE);
      lost_q  <= DATA_VALID_TX && !push_ok;
    end
  end

  // Frame payload and parity; qualified by the FSM, so no reset needed.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  assign tx_out       = tx_q;
  assign busy_flag_TX = busy_q;
  assign data_lost_TX = lost_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: three instances cover even parity,
// odd parity and no-parity/two-stop-bit framing.
module tb_uart_tx_buffered;

  localparam int F = 44;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld   [3];
  logic [7:0] din   [3];
  logic       tx    [3];
  logic       busy  [3];
  logic       lost  [3];
  logic       full  [3];
  logic       empty [3];
  logic [2:0] cnt   [3];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          sel;
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  vec_t        vecs [8];
  logic [7:0]  bw_data  [8];
  logic [10:0] bw_frame [8];

  always #5 clk = ~clk;

  uart_tx_buffered #(.DATA_WIDTH(8), .PAR_EN(1), .PAR_TYPE(0), .STOP_BITS(1),
                     .FIFO_DEPTH(4), .CLKS_PER_BIT(4)) dut0 (
    .clk(clk), .rst(rst), .P_DATA_IN_TX(din[0]), .DATA_VALID_TX(vld[0]),
    .tx_out(tx[0]), .busy_flag_TX(busy[0]), .data_lost_TX(lost[0]),
    .fifo_full(full[0]), .fifo_empty(empty[0]), .fifo_count(cnt[0]));

  uart_tx_buffered #(.DATA_WIDTH(8), .PAR_EN(1), .PAR_TYPE(1), .STOP_BITS(1),
                     .FIFO_DEPTH(4), .CLKS_PER_BIT(4)) dut1 (
    .clk(clk), .rst(rst), .P_DATA_IN_TX(din[1]), .DATA_VALID_TX(vld[1]),
    .tx_out(tx[1]), .busy_flag_TX(busy[1]), .data_lost_TX(lost[1]),
    .fifo_full(full[1]), .fifo_empty(empty[1]), .fifo_count(cnt[1]));

  uart_tx_buffered #(.DATA_WIDTH(8), .PAR_EN(0), .PAR_TYPE(0), .STOP_BITS(2),
                     .FIFO_DEPTH(4), .CLKS_PER_BIT(4)) dut2 (
    .clk(clk), .rst(rst), .P_DATA_IN_TX(din[2]), .DATA_VALID_TX(vld[2]),
    .tx_out(tx[2]), .busy_flag_TX(busy[2]), .data_lost_TX(lost[2]),
    .fifo_full(full[2]), .fifo_empty(empty[2]), .fifo_count(cnt[2]));

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Push npush words (from bw_data) on consecutive cycles; the first nacc are
  // expected on the line back-to-back, the rest dropped with a loss pulse.
  task automatic run_burst(input int sel, input int npush, input int nacc, input string tag);
    int f;
    int j;
    @(negedge clk);
    for (int c = 0; c <= nacc * F + 1; c++) begin
      vld[sel] = (c < npush);
      din[sel] = (c < npush) ? bw_data[c] : 8'h00;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s lost c%0d", tag, c), int'(lost[sel]), int'(c >= nacc && c < npush));
      if (c >= 1 && c <= nacc * F) begin
        f = (c - 1) / F;
        j = (c - 1) % F;
        check($sformatf("%s tx c%0d", tag, c), int'(tx[sel]), int'(bw_frame[f][j / 4]));
        check($sformatf("%s busy c%0d", tag, c), int'(busy[sel]), 1);
      end else begin
        check($sformatf("%s idle tx c%0d", tag, c), int'(tx[sel]), 1);
        check($sformatf("%s idle busy c%0d", tag, c), int'(busy[sel]), 0);
      end
    end
    vld[sel] = 1'b0;
  endtask

  initial begin
    // Expected line bits, index 0 first on the wire: {stop, parity|stop2, data, start}
    vecs[0] = '{0, 8'hA5, 11'b1_0_10100101_0};
    vecs[1] = '{0, 8'h01, 11'b1_1_00000001_0};
    vecs[2] = '{0, 8'h00, 11'b1_0_00000000_0};
    vecs[3] = '{0, 8'hFF, 11'b1_0_11111111_0};
    vecs[4] = '{0, 8'h6D, 11'b1_1_01101101_0};
    vecs[5] = '{1, 8'h00, 11'b1_1_00000000_0};
    vecs[6] = '{1, 8'hA5, 11'b1_1_10100101_0};
    vecs[7] = '{2, 8'hA5, 11'b1_1_10100101_0};

    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      din[i] = 8'h00;
    end

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst tx%0d", i),    int'(tx[i]),    1);
      check($sformatf("rst busy%0d", i),  int'(busy[i]),  0);
      check($sformatf("rst lost%0d", i),  int'(lost[i]),  0);
      check($sformatf("rst cnt%0d", i),   int'(cnt[i]),   0);
      check($sformatf("rst empty%0d", i), int'(empty[i]), 1);
      check($sformatf("rst full%0d", i),  int'(full[i]),  0);
    end
    rst = 1'b0;

    // Single frames from the table
    for (int v = 0; v < 8; v++) begin
      bw_data[0]  = vecs[v].data;
      bw_frame[0] = vecs[v].frame;
      run_burst(vecs[v].sel, 1, 1, $sformatf("vec%0d", v));
    end

    // Six pushes while idle: five accepted, sixth lost, frames back-to-back
    bw_data[0] = 8'h11; bw_frame[0] = 11'b1_0_00010001_0;
    bw_data[1] = 8'h07; bw_frame[1] = 11'b1_1_00000111_0;
    bw_data[2] = 8'hC3; bw_frame[2] = 11'b1_0_11000011_0;
    bw_data[3] = 8'h80; bw_frame[3] = 11'b1_1_10000000_0;
    bw_data[4] = 8'h5A; bw_frame[4] = 11'b1_0_01011010_0;
    bw_data[5] = 8'hEE; bw_frame[5] = 11'b1_0_11101110_0;
    run_burst(0, 6, 5, "burst6");

    // No parity, two stop bits: two frames with no gap
    bw_data[0] = 8'hA5; bw_frame[0] = 11'b1_1_10100101_0;
    bw_data[1] = 8'h3C; bw_frame[1] = 11'b1_1_00111100_0;
    run_burst(2, 2, 2, "stop2");

    // Full queue, push during the last stop cycle of the frame in flight
    @(negedge clk);
    for (int c = 0; c < 48; c++) begin
      vld[0] = (c <= 4) || (c == 45);
      din[0] = 8'(8'h30 + c);
      @(posedge clk);
      @(negedge clk);
      if (c == 4) begin
        check("full cnt c4", int'(cnt[0]), 4);
        check("full flag c4", int'(full[0]), 1);
        check("full lost c4", int'(lost[0]), 0);
      end
      if (c == 44) begin
        check("laststop tx", int'(tx[0]), 1);
        check("laststop cnt", int'(cnt[0]), 4);
      end
      if (c == 45) begin
        check("pushpop cnt", int'(cnt[0]), 4);
        check("pushpop lost", int'(lost[0]), 0);
        check("pushpop full", int'(full[0]), 1);
        check("pushpop nextstart", int'(tx[0]), 0);
        check("pushpop busy", int'(busy[0]), 1);
      end
    end
    vld[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("flush cnt", int'(cnt[0]), 0);
    check("flush busy", int'(busy[0]), 0);

    // Reset during data bit 3 with two words queued
    for (int c = 0; c < 20; c++) begin
      vld[0] = (c < 3);
      din[0] = (c == 0) ? 8'hA5 : 8'h5A;
      rst    = (c == 19);
      @(posedge clk);
      @(negedge clk);
      if (c == 18) begin
        check("midrst bit3 tx", int'(tx[0]), 0);
        check("midrst queued", int'(cnt[0]), 2);
        check("midrst busy", int'(busy[0]), 1);
      end
      if (c == 19) begin
        check("midrst tx", int'(tx[0]), 1);
        check("midrst busy0", int'(busy[0]), 0);
        check("midrst cnt", int'(cnt[0]), 0);
        check("midrst empty", int'(empty[0]), 1);
        check("midrst full", int'(full[0]), 0);
      end
    end
    rst = 1'b0;
    vld[0] = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("postrst idle c%0d", c), int'({tx[0], busy[0], empty[0]}), 3'b101);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
